if_id_pipeline_register: RTL

- Pipeline register between instruction fetch and decode in the 64-bit RISC-V core.
- Captures the PC, PC+4 and instruction word produced by fetch, then presents them to decode through a valid/ready handshake.
- Contains a one-entry skid buffer, so fetch back-pressure comes from registered state only; there is no combinational path from id_ready to if_ready.
- A branch-taken flush from execute discards everything held and presents a NOP bubble.

---
 rtl/if_id_pipeline_register_pkg.sv | 26 ++
 rtl/if_id_payload_reg.sv | 24 ++
 rtl/if_id_pipeline_register.sv | 131 +++++++++++++
 3 files changed

// File: rtl/if_id_pipeline_register_pkg.sv
// Shared definitions for the IF/ID pipeline register: widths, NOP encoding,
// handshake state encoding and the payload layout.
package if_id_pipeline_register_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   // addi x0, x0, 0
   localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

   // 2'd3 is unused and recovers to EMPTY.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [ILEN-1:0] inst;
   } payload_t;

   localparam int unsigned PAYLOAD_W = $bits(payload_t);

endpackage

// File: rtl/if_id_payload_reg.sv
// One payload entry (pc, pc4, inst) with load enable and asynchronous
// active-low reset; used for both the main and the skid entry.
module if_id_payload_reg
   import if_id_pipeline_register_pkg::*;
#(
   parameter int unsigned      Width    = PAYLOAD_W,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= ResetVal;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register with a one-entry skid buffer; fetch back-pressure is
// decoded from registered state only, and flush replaces the held work with a bubble.
module if_id_pipeline_register
   import if_id_pipeline_register_pkg::*;
#(
   parameter int unsigned     XLEN     = if_id_pipeline_register_pkg::XLEN,
   parameter int unsigned     ILEN     = if_id_pipeline_register_pkg::ILEN,
   parameter logic [ILEN-1:0] NOP_INST = if_id_pipeline_register_pkg::NOP_INST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_pc,
   input  logic [XLEN-1:0] if_pc4,
   input  logic [ILEN-1:0] if_inst,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc4,
   output logic [ILEN-1:0] id_inst
);

   localparam int unsigned PW = 2 * XLEN + ILEN;

   state_e        state_q, state_d;
   logic          if_ready_q, id_valid_q;
   logic          in_fire, out_fire;
   logic          main_load, skid_load;
   logic [PW-1:0] in_payload, main_bubble;
   logic [PW-1:0] main_d, main_q, skid_d, skid_q;

   assign in_payload = {if_pc, if_pc4, if_inst};
   assign in_fire    = if_valid & if_ready_q;
   assign out_fire   = id_valid_q & id_ready;

   // Empty main keeps its pc/pc4 but must present a NOP.
   assign main_bubble = {main_q[PW-1:ILEN], NOP_INST};

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      main_d    = in_payload;
      skid_load = 1'b0;
      skid_d    = in_payload;
      if (flush) begin
         state_d   = EMPTY;
         main_load = 1'b1;
         main_d    = main_bubble;
         skid_load = 1'b1;
         skid_d    = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d   = FULL;
                  main_load = 1'b1;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_d   = SKID;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_d   = EMPTY;
                  main_load = 1'b1;
                  main_d    = main_bubble;
               end
            end
            SKID: begin
               if (out_fire) begin
                  state_d   = FULL;
                  main_load = 1'b1;
                  main_d    = skid_q;
               end
            end
            default: begin
               state_d   = EMPTY;
               main_load = 1'b1;
               main_d    = main_bubble;
            end
         endcase
      end
   end

   // Handshake flags are registered from the next state so neither output
   // depends combinationally on any input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= EMPTY;
         if_ready_q <= 1'b1;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         if_ready_q <= (state_d != SKID);
         id_valid_q <= (state_d != EMPTY);
      end
   end

   if_id_payload_reg #(
      .Width    (PW),
      .ResetVal ({{(2 * XLEN){1'b0}}, NOP_INST})
   ) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   if_id_payload_reg #(
      .Width    (PW),
      .ResetVal ('0)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load),
      .d    (skid_d),
      .q    (skid_q)
   );

   assign if_ready = if_ready_q;
   assign id_valid = id_valid_q;
   assign id_pc    = main_q[PW-1 -: XLEN];
   assign id_pc4   = main_q[ILEN +: XLEN];
   assign id_inst  = main_q[ILEN-1:0];

endmodule
